// File: rtl/seg_scan_if.sv
// Load/display bundle between a frame source and the seg_scan_ctrl scan controller.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic [3:0]                dig_val;
    logic [NUM_DIGITS-1:0]     dig_en;
    logic                      upd_done;
    logic                      pending;

    modport master (
        output load, load_data,
        input  dig_val, dig_en, upd_done, pending
    );

    modport slave (
        input  load, load_data,
        output dig_val, dig_en, upd_done, pending
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with tear-free frame updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FW    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FW-1:0]           disp_q, disp_d;
    logic [FW-1:0]           pend_q, pend_d;
    logic                    pending_q, pending_d;
    logic                    upd_q, upd_d;
    logic [3:0]              val_q, val_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic                    frame_end;

`ifdef SEG_SCAN_LZB_EN
    function automatic logic upper_zero(input logic [FW-1:0] v, input logic [IDX_W-1:0] k);
        logic z;
        z = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (IDX_W'(i) >= k && v[4*i +: 4] != 4'h0) z = 1'b0;
        return z;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            upd_q     <= 1'b0;
            val_q     <= 4'hF;
            en_q      <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            upd_q     <= upd_d;
            val_q     <= val_d;
            en_q      <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            BLANK: if (cnt_q == BLANK_LAST) begin
                state_d = SHOW;
                cnt_d   = '0;
            end
            SHOW: if (cnt_q == DWELL_LAST) begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // A staged frame is committed only on the edge that ends the last digit's dwell.
    assign frame_end = (state_q == SHOW) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);

    always_comb begin
        pend_d    = bus.load ? bus.load_data : pend_q;
        pending_d = bus.load ? 1'b1 : (frame_end ? 1'b0 : pending_q);
        disp_d    = (frame_end && pending_q) ? pend_q : disp_q;
        upd_d     = frame_end && pending_q;
    end

    // Outputs are registered from next-state values so enables line up with the FSM state.
    always_comb begin
        en_d  = '1;
        val_d = 4'hF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                val_d = disp_d[4*i +: 4];
                if (state_d == SHOW) en_d[i] = 1'b0;
            end
        end
`ifdef SEG_SCAN_LZB_EN
        if (idx_d != '0 && upper_zero(disp_d, idx_d)) val_d = 4'hF;
`endif
    end

    assign bus.dig_val  = val_q;
    assign bus.dig_en   = en_q;
    assign bus.upd_done = upd_q;
    assign bus.pending  = pending_q;
endmodule
